// File: rtl/seq_mult_4x4.sv
// Sequential unsigned multiplier: splits each captured operand into DIG_W-bit
// digits and shift-accumulates one digit-by-digit partial product per cycle.
// A one-cycle done pulse follows the last step; product holds until the next
// completed multiply (or reset).
module seq_mult_4x4 #(
  parameter int WIDTH = 4,
  parameter int DIG_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int ND = WIDTH / DIG_W;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * DIG_W;
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    acc_q, product_q;
  logic [CW-1:0]    i_q, j_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIG_W-1:0] a_dig, b_dig;
  logic [PW-1:0]    pp;
  logic [AW-1:0]    term, acc_d;
  logic             last_i, last_j;

  // Select current digits, form the partial product and the next accumulator.
  always_comb begin
    a_sh   = a_q >> (DIG_W * int'(i_q));
    b_sh   = b_q >> (DIG_W * int'(j_q));
    a_dig  = a_sh[DIG_W-1:0];
    b_dig  = b_sh[DIG_W-1:0];
    pp     = {{DIG_W{1'b0}}, a_dig} * {{DIG_W{1'b0}}, b_dig};
    term   = {{(AW-PW){1'b0}}, pp} << (DIG_W * (int'(i_q) + int'(j_q)));
    acc_d  = acc_q + term;
    last_i = (i_q == CW'(ND - 1));
    last_j = (j_q == CW'(ND - 1));
  end

  // Controller and datapath registers; outputs are registered alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_MUL: begin
          if (last_i && last_j) begin
            // Final step bypasses acc so the result lands with the done pulse.
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            acc_q <= acc_d;
            // j steps fastest, wrapping into i.
            if (last_j) begin
              j_q <= '0;
              i_q <= i_q + CW'(1);
            end else begin
              j_q <= j_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Bench for seq_mult_4x4: reference is plain a*b with an ND^2-cycle busy
// window followed by a single done cycle; product must hold otherwise.
module tb_seq_mult_4x4;
  localparam int W     = 4;
  localparam int STEPS = (W / 2) * (W / 2);

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   a_in, b_in;
  logic [2*W-1:0] product;
  logic           busy, done;
  logic [2*W+1:0] obs;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W-1:0] exp_prod;

  always #5 clk = ~clk;

  seq_mult_4x4 #(.WIDTH(W), .DIG_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .product(product), .busy(busy), .done(done)
  );

  assign obs = {busy, done, product};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2*W+1:0] e;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    e = '0;
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL reset_held: {busy,done,product}=%h expected %h", obs, e);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL reset_release: {busy,done,product}=%h expected %h", obs, e);
    end
    exp_prod = '0;
  endtask

  // Directed vectors plus random ones, each with full cycle-by-cycle timing checks.
  task automatic test_basic();
    int va[10], vb[10];
    logic [2*W+1:0] e;
    va[0] = 3;  vb[0] = 2;
    va[1] = 15; vb[1] = 15;
    va[2] = 10; vb[2] = 5;
    va[3] = 0;  vb[3] = 9;
    for (int n = 4; n < 10; n++) begin
      va[n] = $urandom_range(15); vb[n] = $urandom_range(15);
    end
    for (int n = 0; n < 10; n++) begin
      start = 1'b1; a_in = W'(va[n]); b_in = W'(vb[n]);
      tick();
      start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
      for (int k = 0; k < STEPS; k++) begin
        e = {1'b1, 1'b0, exp_prod};
        n_cmp++;
        if (obs !== e) begin
          n_err++; $display("FAIL basic_busy %0d*%0d k=%0d: got %h expected %h", va[n], vb[n], k, obs, e);
        end
        tick();
      end
      exp_prod = (2*W)'(va[n] * vb[n]);
      e = {1'b0, 1'b1, exp_prod};
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL basic_done %0d*%0d: got %h expected %h", va[n], vb[n], obs, e);
      end
      tick();
      e = {1'b0, 1'b0, exp_prod};
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL basic_idle %0d*%0d: got %h expected %h", va[n], vb[n], obs, e);
      end
    end
  endtask

  // start and operand changes during MUL/DONE must not affect the result or queue.
  task automatic test_ignore_start();
    int dones = 0;
    logic [2*W+1:0] e;
    start = 1'b1; a_in = 4'd7; b_in = 4'd9;
    tick();
    a_in = 4'd1; b_in = 4'd1;
    for (int k = 0; k < STEPS + 1; k++) begin
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    exp_prod = 8'd63;
    for (int k = 0; k < 4; k++) begin
      if (done) dones++;
      e = {1'b0, 1'b0, exp_prod};
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL ignore_idle k=%0d: got %h expected %h", k, obs, e);
      end
      tick();
    end
    n_cmp++;
    if (dones !== 1) begin
      n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
  endtask

  // Held start: one op every STEPS+2 cycles.
  task automatic test_back_to_back();
    int period = STEPS + 2;
    int ph;
    logic [2*W+1:0] e;
    start = 1'b1; a_in = 4'd6; b_in = 4'd6;
    tick();
    for (int cyc = 0; cyc < 3 * period; cyc++) begin
      ph = cyc % period;
      if (cyc >= STEPS) exp_prod = 8'd36;
      e = {(ph < STEPS), (ph == STEPS), exp_prod};
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL b2b cyc=%0d: got %h expected %h", cyc, obs, e);
      end
      if (cyc == 3 * period - 1) start = 1'b0;
      tick();
    end
    e = {1'b0, 1'b0, exp_prod};
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL b2b_stop: got %h expected %h", obs, e);
    end
  endtask

  // Reset during the 3rd MUL cycle aborts without a done pulse.
  task automatic test_reset_abort();
    int dones = 0;
    logic [2*W+1:0] e;
    start = 1'b1; a_in = 4'd12; b_in = 4'd13;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    exp_prod = '0;
    e = '0;
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL abort_async: got %h expected %h", obs, e);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0 || obs !== e) begin
      n_err++; $display("FAIL abort_quiet: dones=%0d obs=%h expected 0 and %h", dones, obs, e);
    end
    start = 1'b1; a_in = 4'd2; b_in = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < STEPS; k++) tick();
    e = {1'b0, 1'b1, 8'd6};
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL abort_next_op: got %h expected %h", obs, e);
    end
    exp_prod = 8'd6;
    tick();
  endtask

  // All operand pairs; product must hold its previous value until done.
  task automatic test_exhaustive();
    logic [2*W+1:0] e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start = 1'b1; a_in = W'(a); b_in = W'(b);
        tick();
        start = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
          e = {1'b1, 1'b0, exp_prod};
          n_cmp++;
          if (obs !== e) begin
            n_err++; $display("FAIL exh_hold %0d*%0d k=%0d: got %h expected %h", a, b, k, obs, e);
          end
          tick();
        end
        exp_prod = (2*W)'(a * b);
        e = {1'b0, 1'b1, exp_prod};
        n_cmp++;
        if (obs !== e) begin
          n_err++; $display("FAIL exh_done %0d*%0d: got %h expected %h", a, b, obs, e);
        end
        tick();
      end
    end
  endtask

  // Random ops, random gaps, noise on start/operands while busy.
  task automatic test_random();
    int a, b, gap;
    logic [2*W+1:0] e;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(15); b = $urandom_range(15);
      start = 1'b1; a_in = W'(a); b_in = W'(b);
      tick();
      for (int k = 0; k < STEPS; k++) begin
        start = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom);
        tick();
      end
      exp_prod = (2*W)'(a * b);
      e = {1'b0, 1'b1, exp_prod};
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL rand_done %0d*%0d: got %h expected %h", a, b, obs, e);
      end
      tick();
      start = 1'b0;
      gap = $urandom_range(3);
      for (int g = 0; g < gap; g++) begin
        tick();
        e = {1'b0, 1'b0, exp_prod};
        n_cmp++;
        if (obs !== e) begin
          n_err++; $display("FAIL rand_gap %0d*%0d g=%0d: got %h expected %h", a, b, g, obs, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
